// File: rtl/ultrasonic_pkg.sv
// Shared constants for the ultrasonic distance filter: FSM encoding,
// echo saturation code and averaging window geometry.
package ultrasonic_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DIVIDE = 2'd1;
    localparam logic [1:0] ST_ACCUM  = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    localparam logic [15:0] ECHO_SAT = 16'hFFFF;

    localparam int WIN_DEPTH = 4;
    localparam int WIN_AW    = 2;
    localparam int SUM_W     = 18;

endpackage

// File: rtl/seq_divider16.sv
// 16-bit restoring shift-subtract divider, one quotient bit per clock.
// The start cycle already resolves the first bit, so done pulses 16 edges after start.
module seq_divider16
    import ultrasonic_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] dividend,
    input  logic [15:0] divisor,
    output logic [15:0] quotient,
    output logic        done
);

    logic [15:0] rem;
    logic [15:0] quo;
    logic [3:0]  iter;
    logic        running;

    logic [15:0] rem_src;
    logic [15:0] quo_src;
    logic [16:0] trial;
    logic        take;

    always_comb begin
        rem_src = start ? 16'd0 : rem;
        quo_src = start ? dividend : quo;
        trial   = {rem_src, quo_src[15]};
        take    = (trial >= {1'b0, divisor});
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rem     <= '0;
            quo     <= '0;
            iter    <= '0;
            running <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start || running) begin
                // remainder always stays below divisor, so 16 bits hold it
                rem <= take ? 16'(trial - {1'b0, divisor}) : trial[15:0];
                quo <= {quo_src[14:0], take};
            end
            if (start) begin
                iter    <= 4'd1;
                running <= 1'b1;
            end else if (running) begin
                iter <= iter + 4'd1;
                if (iter == 4'd15) begin
                    running <= 1'b0;
                    done    <= 1'b1;
                end
            end
        end
    end

    assign quotient = quo;

endmodule

// File: rtl/ultrasonic_distance_filter.sv
// Converts raw echo widths to centimetres and smooths them with a 4-entry
// moving average; saturated echoes are reported but never enter the window.
//
// state  | meaning
// IDLE   | waiting for echo_valid
// DIVIDE | divider running (one settle cycle only for a saturated echo)
// ACCUM  | window write, running sum and dist_cm update
// DONE   | dist_valid / overrange presented, back to IDLE
module ultrasonic_distance_filter
    import ultrasonic_pkg::*;
#(
    parameter int unsigned DIV_CONST = 58,
    parameter int unsigned NEAR_CM   = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] echo_count,
    input  logic        echo_valid,
    output logic [15:0] dist_cm,
    output logic        dist_valid,
    output logic        overrange,
    output logic        near_alarm,
    output logic        busy,
    output logic        sample_dropped
);

    localparam logic [15:0] DIVISOR = 16'(DIV_CONST);
    localparam logic [15:0] NEAR_TH = 16'(NEAR_CM);

    logic [1:0]        state;
    logic              cap_sat;
    logic              primed;
    logic [15:0]       win [WIN_DEPTH];
    logic [WIN_AW-1:0] wr_ptr;
    logic [SUM_W-1:0]  sum;

    logic              div_start;
    logic              div_done;
    logic [15:0]       quotient;
    logic [SUM_W-1:0]  sum_next;
    logic [15:0]       avg_next;

    assign busy      = (state != ST_IDLE);
    assign div_start = (state == ST_IDLE) && echo_valid && (echo_count != ECHO_SAT);

    seq_divider16 u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (div_start),
        .dividend (echo_count),
        .divisor  (DIVISOR),
        .quotient (quotient),
        .done     (div_done)
    );

    // first sample primes every slot, so the sum is simply 4x the quotient
    always_comb begin
        if (primed)
            sum_next = sum + SUM_W'(quotient) - SUM_W'(win[wr_ptr]);
        else
            sum_next = {quotient, 2'b00};
        avg_next = sum_next[SUM_W-1:2];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            cap_sat        <= 1'b0;
            primed         <= 1'b0;
            wr_ptr         <= '0;
            sum            <= '0;
            dist_cm        <= '0;
            dist_valid     <= 1'b0;
            overrange      <= 1'b0;
            near_alarm     <= 1'b0;
            sample_dropped <= 1'b0;
            for (int i = 0; i < WIN_DEPTH; i++)
                win[i] <= '0;
        end else begin
            dist_valid     <= 1'b0;
            sample_dropped <= busy && echo_valid;
            case (state)
                ST_IDLE: begin
                    if (echo_valid) begin
                        cap_sat <= (echo_count == ECHO_SAT);
                        state   <= ST_DIVIDE;
                    end
                end
                ST_DIVIDE: begin
                    if (cap_sat)
                        state <= ST_DONE;
                    else if (div_done)
                        state <= ST_ACCUM;
                end
                ST_ACCUM: begin
                    if (primed) begin
                        win[wr_ptr] <= quotient;
                        wr_ptr      <= wr_ptr + 1'b1;
                    end else begin
                        for (int i = 0; i < WIN_DEPTH; i++)
                            win[i] <= quotient;
                        primed <= 1'b1;
                    end
                    sum        <= sum_next;
                    dist_cm    <= avg_next;
                    near_alarm <= (avg_next < NEAR_TH);
                    state      <= ST_DONE;
                end
                ST_DONE: begin
                    dist_valid <= 1'b1;
                    overrange  <= cap_sat;
                    state      <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ultrasonic_distance_filter.sv
// Bench for ultrasonic_distance_filter: queue-based averaging model checked every
// cycle, plus literal expectations on latency and distances for directed echoes.
module tb_ultrasonic_distance_filter;

    localparam int DIV  = 58;
    localparam int NEAR = 15;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] echo_count = '0;
    logic        echo_valid = 1'b0;
    logic [15:0] dist_cm;
    logic        dist_valid;
    logic        overrange;
    logic        near_alarm;
    logic        busy;
    logic        sample_dropped;

    always #5 clk = ~clk;

    ultrasonic_distance_filter #(.DIV_CONST(DIV), .NEAR_CM(NEAR)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .echo_count     (echo_count),
        .echo_valid     (echo_valid),
        .dist_cm        (dist_cm),
        .dist_valid     (dist_valid),
        .overrange      (overrange),
        .near_alarm     (near_alarm),
        .busy           (busy),
        .sample_dropped (sample_dropped)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    bit en = 0;

    // model: window of last four cm readings
    int mwin[$];
    bit mprimed;
    int mdist;
    bit mnear;
    bit pend_active;
    int pend_edge, p_dist;
    bit p_ovr, p_near;
    bit have_acc;
    int acc_edge, free_edge, drop_edge;

    int last_dist, last_valid_edge, valid_count = 0, drop_count = 0, issue_edge;
    bit last_ovr, last_near;
    bit exp_valid;

    function automatic void chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void model_reset();
        mwin.delete();
        mprimed     = 0;
        mdist       = 0;
        mnear       = 0;
        pend_active = 0;
        have_acc    = 0;
        free_edge   = 0;
        drop_edge   = -1;
    endfunction

    function automatic void model_issue(int e, int v);
        int s;
        if (e < free_edge) begin
            drop_edge = e;
            return;
        end
        have_acc    = 1;
        acc_edge    = e;
        pend_active = 1;
        if (v == 65535) begin
            p_ovr     = 1;
            pend_edge = e + 2;
            free_edge = e + 3;
        end else begin
            if (!mprimed) begin
                mwin    = '{v / DIV, v / DIV, v / DIV, v / DIV};
                mprimed = 1;
            end else begin
                mwin.push_back(v / DIV);
                void'(mwin.pop_front());
            end
            s = 0;
            foreach (mwin[i]) s += mwin[i];
            mdist     = s / 4;
            mnear     = (mdist < NEAR);
            p_ovr     = 0;
            pend_edge = e + 18;
            free_edge = e + 19;
        end
        p_dist = mdist;
        p_near = mnear;
    endfunction

    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        if (en) begin
            exp_valid = pend_active && (cyc == pend_edge);
            chk("dist_valid", int'(dist_valid), int'(exp_valid));
            chk("sample_dropped", int'(sample_dropped), int'(cyc == drop_edge));
            chk("busy", int'(busy), int'(have_acc && cyc >= acc_edge && cyc <= free_edge - 2));
            if (exp_valid) begin
                chk("dist_cm", int'(dist_cm), p_dist);
                chk("overrange", int'(overrange), int'(p_ovr));
                chk("near_alarm", int'(near_alarm), int'(p_near));
                pend_active = 0;
            end
            if (dist_valid) begin
                last_dist       = int'(dist_cm);
                last_ovr        = overrange;
                last_near       = near_alarm;
                last_valid_edge = cyc;
                valid_count++;
            end
            if (sample_dropped) drop_count++;
        end
    end

    task automatic pulse(input int v);
        @(negedge clk);
        echo_count = 16'(v);
        echo_valid = 1'b1;
        issue_edge = cyc + 1;
        model_issue(cyc + 1, v);
        @(negedge clk);
        echo_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (pend_active && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (pend_active) begin
            checks++;
            errors++;
            $display("FAIL timeout: dist_valid not seen by edge %0d, expected at %0d", cyc, pend_edge);
            pend_active = 0;
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_dist_cm"}, int'(dist_cm), 0);
        chk({tag, "_dist_valid"}, int'(dist_valid), 0);
        chk({tag, "_overrange"}, int'(overrange), 0);
        chk({tag, "_near"}, int'(near_alarm), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_dropped"}, int'(sample_dropped), 0);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        #2;
        chk_zero(tag);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic expect_last(input string tag, input int lat, input int d, input int ovr, input int nr);
        chk({tag, "_latency"}, last_valid_edge - issue_edge, lat);
        chk({tag, "_dist"}, last_dist, d);
        chk({tag, "_ovr"}, int'(last_ovr), ovr);
        chk({tag, "_near"}, int'(last_near), nr);
    endtask

    initial begin
        int vc0, dc0, e1;
        model_reset();
        do_reset("reset");
        en = 1;

        pulse(580);   wait_done(); expect_last("s580", 18, 10, 0, 1);
        pulse(1160);  wait_done(); expect_last("s1160", 18, 12, 0, 1);
        for (int i = 0; i < 3; i++) begin
            pulse(1160); wait_done();
        end
        expect_last("fill20", 18, 20, 0, 0);
        pulse(65535); wait_done(); expect_last("sat", 2, 20, 1, 0);
        pulse(580);   wait_done(); expect_last("post_sat", 18, 17, 0, 0);

        // second echo five cycles into the first one must be dropped
        vc0 = valid_count;
        dc0 = drop_count;
        pulse(580);
        e1 = issue_edge;
        repeat (3) @(negedge clk);
        pulse(1160);
        wait_done();
        repeat (3) @(negedge clk);
        chk("drop_valid_count", valid_count - vc0, 1);
        chk("drop_pulse_count", drop_count - dc0, 1);
        chk("drop_first_latency", last_valid_edge - e1, 18);
        chk("drop_first_dist", last_dist, 15);
        chk("drop_first_near", int'(last_near), 0);

        // reset on the eighth DIVIDE cycle aborts the sample
        vc0 = valid_count;
        pulse(580);
        repeat (6) @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        #2;
        chk_zero("abort");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (15) @(negedge clk);
        chk("abort_no_valid", valid_count, vc0);
        pulse(290);   wait_done(); expect_last("reprime", 18, 5, 0, 1);

        do_reset("reset2");
        pulse(57);    wait_done(); expect_last("trunc57", 18, 0, 0, 1);
        pulse(0);     wait_done(); expect_last("zero", 18, 0, 0, 1);
        pulse(65534); wait_done(); expect_last("max", 18, 282, 0, 0);
        pulse(65535); wait_done(); expect_last("sat2", 2, 282, 1, 0);
        pulse(580);   wait_done(); expect_last("after_sat2", 18, 284, 0, 0);
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish by edge %0d", cyc);
        $fatal(1);
    end

endmodule

// File: doc/ultrasonic_distance_filter.md
ULTRASONIC_DISTANCE_FILTER -- requirements
Module: ultrasonic_distance_filter

Interface
REQ-001 SHALL have parameter DIV_CONST, default 58, meaning echo clock ticks per centimetre (valid range 1..65535).
REQ-002 SHALL have parameter NEAR_CM, default 15, meaning the near-alarm threshold in cm.
REQ-003 SHALL have port clk  input  1  meaning the single system clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_n  input  1  meaning reset, synchronous and active-low.
REQ-005 SHALL have port echo_count  input  16  meaning the raw echo width in ticks from the upstream ultrasonic sensor stage; 16'hFFFF means saturated.
REQ-006 SHALL have port echo_valid  input  1  meaning a one-cycle strobe that echo_count holds a new measurement.
REQ-007 SHALL have port dist_cm  output  16  meaning the filtered distance in cm.
REQ-008 SHALL have port dist_valid  output  1  meaning a one-cycle strobe that marks a completed sample.
REQ-009 SHALL have port overrange  output  1  meaning the last completed sample was saturated; valid with dist_valid.
REQ-010 SHALL have port near_alarm  output  1  meaning the level flag dist_cm < NEAR_CM.
REQ-011 SHALL have port busy  output  1  meaning the FSM is not in IDLE.
REQ-012 SHALL have port sample_dropped  output  1  meaning a one-cycle pulse when echo_valid arrives while busy.

Function
REQ-013 SHALL implement FSM states IDLE, DIVIDE, ACCUM and DONE.
REQ-014 In IDLE, SHALL capture echo_count on echo_valid=1 at edge N and go to DIVIDE.
REQ-015 In DIVIDE, SHALL compute quotient = capture / DIV_CONST using a 16-iteration restoring shift-subtract divider, one bit per cycle (cycles N+1..N+16), and discard the remainder.
REQ-016 In ACCUM (cycle N+17), SHALL write the quotient into a 4-entry ring window, update the running sum, and set dist_cm = sum >> 2 (truncating).
REQ-017 The running sum SHALL be 18 bits wide, SHALL be updated as sum + new - oldest, and SHALL never overflow.
REQ-018 SHALL assert dist_valid in cycle N+18 (DONE), then return to IDLE; a new echo_valid is accepted from the IDLE cycle that follows.
REQ-019 On the first non-saturated sample after reset, SHALL load all 4 window entries with the quotient (priming), so dist_cm equals that quotient.
REQ-020 For a saturated capture (16'hFFFF), SHALL skip DIVIDE and ACCUM, pulse dist_valid with overrange=1 at N+2, hold dist_cm, and leave the window unchanged.
REQ-021 For a non-saturated sample, SHALL clear overrange to 0.
REQ-022 For echo_count=0, SHALL produce a quotient of 0, which is a legal sample.
REQ-023 On echo_valid while busy=1, SHALL ignore the sample, pulse sample_dropped the next cycle, and leave the in-flight computation undisturbed.
REQ-024 SHALL update near_alarm in the same cycle as dist_cm; near_alarm is not changed by overrange samples.

Reset
REQ-025 While rst_n=0 at a rising edge, SHALL force state=IDLE, dist_cm=0, dist_valid=0, overrange=0, near_alarm=0, busy=0, sample_dropped=0, clear the window and sum, and clear the primed flag.
REQ-026 Reset mid-DIVIDE or mid-ACCUM SHALL abort the operation with no dist_valid and no partial window write.

Structure
REQ-027 SHALL place the FSM state encoding, the saturation constant 16'hFFFF and the window depth 4 in a shared package, ultrasonic_pkg.
REQ-028 SHALL implement the divider as one sub-module, seq_divider16 (start/done handshake, 16-cycle fixed latency); the window, sum and FSM remain in the top module.

Verification (DIV_CONST=58, NEAR_CM=15)
REQ-029 After reset, echo_count=580 with echo_valid -> dist_valid at +18 cycles, dist_cm=10, near_alarm=1, overrange=0.
REQ-030 Then echo_count=1160 -> window [10,10,10,20], dist_cm=12, near_alarm=1; then three more samples of 1160 -> dist_cm=20, near_alarm=0.
REQ-031 echo_count=16'hFFFF -> dist_valid at +2 cycles, overrange=1, dist_cm unchanged; the next sample of 580 yields an average without the saturated entry.
REQ-032 A second echo_valid 5 cycles after the first -> sample_dropped pulses once, the first result is correct, and exactly one dist_valid is produced.
REQ-033 rst_n=0 at cycle 8 of DIVIDE -> no dist_valid, all outputs 0, and the next sample of 290 primes the window to dist_cm=5.
REQ-034 echo_count=57 -> dist_cm=0 (truncation), near_alarm=1.
